uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of 2, range 2..16.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; SHALL clear all state immediately on falling edge.
REQ-004 Rx_DATA  input  8  received byte from the UART receiver, stable while Rx_VALID high.
REQ-005 Rx_VALID  input  1  level; high for one or more cycles per received byte.
REQ-006 Rx_FERROR  input  1  framing-error pulse from receiver.
REQ-007 Rx_PERROR  input  1  parity-error pulse from receiver.
REQ-008 rd_en  input  1  consumer read request, sampled each cycle.
REQ-009 clr_err  input  1  synchronous clear of overflow and error counters.
REQ-010 rd_data  output  8  byte popped by the last accepted read.
REQ-011 rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
REQ-012 empty  output  1  high when count == 0.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 count  output  5  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-016 ferr_count  output  8  saturating count of framing errors.
REQ-017 perr_count  output  8  saturating count of parity errors.

Function
REQ-018 Write event SHALL be the rising edge of Rx_VALID, detected against a registered copy; a level held N cycles SHALL produce exactly one write.
REQ-019 On a write event with full low, Rx_DATA SHALL be stored at wr_ptr, wr_ptr SHALL advance mod DEPTH, and count SHALL increment.
REQ-020 On a write event with full high and no accepted read, the byte SHALL be dropped and overflow SHALL set on the next edge.
REQ-021 An accepted read (rd_en high, empty low) SHALL load rd_data from rd_ptr, advance rd_ptr mod DEPTH, decrement count, and pulse rd_valid. Latency is 1 cycle: rd_data and rd_valid are valid on the edge after the rd_en sample.
REQ-022 rd_en while empty SHALL be ignored: rd_valid stays low and rd_data holds.
REQ-023 Simultaneous accepted read and write SHALL both complete with count unchanged. When full, the write SHALL be accepted because the read frees a slot, and overflow SHALL not set.
REQ-024 Simultaneous write and rd_en while empty SHALL perform the write only; the byte is readable from the next cycle.
REQ-025 Pointers SHALL be log2(DEPTH) bits and wrap naturally; full/empty SHALL derive from count, never from pointer equality alone.
REQ-026 Each rising edge of Rx_FERROR or Rx_PERROR SHALL increment the respective counter by 1, saturating at 255.
REQ-027 clr_err SHALL zero overflow, ferr_count and perr_count on the next edge. It SHALL not affect FIFO contents.
REQ-028 A simultaneous clr_err and error/overflow event: clear SHALL win and the counter SHALL read 0.
REQ-029 Error pulses SHALL never write data into the FIFO.

Reset
REQ-030 While reset is low: pointers=0, count=0, empty=1, full=0, rd_data=0x00, rd_valid=0, overflow=0, ferr_count=0, perr_count=0, Rx_VALID/error edge registers=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes; the first write after release SHALL land at entry 0.
REQ-032 Rx_VALID already high at reset release SHALL count as one write event on the first clock after release.

Verification
REQ-033 Rx_VALID high 5 cycles with Rx_DATA=0xA5 -> count=1; one rd_en -> rd_data=0xA5, rd_valid one pulse, empty=1.
REQ-034 Write 0x01..0x08 (DEPTH=8) -> full=1. Then write 0x09 -> overflow=1, count=8. Read 8 -> sequence 0x01..0x08.
REQ-035 Full FIFO, Rx_VALID rising edge and rd_en in the same cycle -> rd_data=oldest byte, count=8, overflow=0, new byte read last.
REQ-036 300 Rx_FERROR pulses -> ferr_count=255; clr_err -> 0. 3 Rx_PERROR pulses -> perr_count=3.
REQ-037 rd_en with empty=1 -> rd_valid=0, rd_data unchanged. Write 0x3C and rd_en in the same cycle while empty -> count=1, no rd_valid.
REQ-038 Fill 5 bytes, assert reset low mid-stream -> count=0, empty=1 immediately. After release, write 0x77 and read -> 0x77.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: Rx_VALID rising edges enqueue, rd_en pops with 1-cycle latency.
// A write while full is dropped (sticky overflow) unless a read frees a slot in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Rx_DATA,
   input  logic       Rx_VALID,
   input  logic       Rx_FERROR,
   input  logic       Rx_PERROR,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       empty,
   output logic       full,
   output logic [4:0] count,
   output logic       overflow,
   output logic [7:0] ferr_count,
   output logic [7:0] perr_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    ferr_cnt_q, ferr_cnt_d;
   logic [7:0]    perr_cnt_q, perr_cnt_d;
   logic          rx_vld_q, rx_vld_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;

   logic wr_evt, rd_acc, wr_acc, is_full, is_empty;

   assign is_empty = (count_q == 5'd0);
   assign is_full  = (count_q == 5'(DEPTH));
   assign wr_evt   = Rx_VALID & ~rx_vld_q;
   assign rd_acc   = rd_en & ~is_empty;
   // A same-cycle read frees the slot the full-FIFO write lands in.
   assign wr_acc   = wr_evt & (~is_full | rd_acc);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      overflow_d = overflow_q;
      ferr_cnt_d = ferr_cnt_q;
      perr_cnt_d = perr_cnt_q;
      rx_vld_d   = Rx_VALID;
      ferr_d     = Rx_FERROR;
      perr_d     = Rx_PERROR;

      if (rd_acc) begin
         rd_data_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      if (wr_acc) begin
         mem_d[wr_ptr_q] = Rx_DATA;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase

      if (wr_evt && !wr_acc) overflow_d = 1'b1;
      if (Rx_FERROR && !ferr_q && ferr_cnt_q != 8'hFF) ferr_cnt_d = ferr_cnt_q + 8'd1;
      if (Rx_PERROR && !perr_q && perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'd1;
      // Clear has priority over any same-cycle error or overflow event.
      if (clr_err) begin
         overflow_d = 1'b0;
         ferr_cnt_d = 8'd0;
         perr_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q      <= '{default: 8'h00};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 5'd0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         ferr_cnt_q <= 8'd0;
         perr_cnt_q <= 8'd0;
         rx_vld_q   <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         ferr_cnt_q <= ferr_cnt_d;
         perr_cnt_q <= perr_cnt_d;
         rx_vld_q   <= rx_vld_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign empty      = is_empty;
   assign full       = is_full;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign ferr_count = ferr_cnt_q;
   assign perr_count = perr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8); expected bytes queued at write, checked at read.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_FERROR;
   logic       Rx_PERROR;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] ferr_count;
   logic [7:0] perr_count;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb[$];
   logic [7:0] last_rd = 8'h00;

   uart_rx_fifo #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
      .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .rd_en(rd_en), .clr_err(clr_err),
      .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .ferr_count(ferr_count), .perr_count(perr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b, input bit accept);
      Rx_DATA  = b;
      Rx_VALID = 1'b1;
      tick();
      Rx_VALID = 1'b0;
      tick();
      if (accept) sb.push_back(b);
   endtask

   task automatic do_read(input string tag);
      logic [7:0] e;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: observed read with empty scoreboard, expected no data", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, {24'd0, rd_data}, {24'd0, e});
         last_rd = e;
      end
      tick();
      chk({tag, "_pulse"}, {31'd0, rd_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0;
      Rx_PERROR = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      tick();
      tick();
      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_ferr", {24'd0, ferr_count}, 32'd0);
      chk("rst_perr", {24'd0, perr_count}, 32'd0);
      reset = 1'b1;
      tick();

      // Level held 5 cycles yields a single write.
      Rx_DATA = 8'hA5; Rx_VALID = 1'b1;
      repeat (5) tick();
      Rx_VALID = 1'b0;
      sb.push_back(8'hA5);
      tick();
      chk("hold5_count", {27'd0, count}, 32'd1);
      do_read("hold5_rd");
      chk("hold5_empty", {31'd0, empty}, 32'd1);

      // Fill, overflow, clear with data present, then drain in order.
      for (int i = 1; i <= 8; i++) write_byte(8'(i), 1'b1);
      chk("fill_full", {31'd0, full}, 32'd1);
      chk("fill_count", {27'd0, count}, 32'd8);
      chk("fill_ovf0", {31'd0, overflow}, 32'd0);
      write_byte(8'h09, 1'b0);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {27'd0, count}, 32'd8);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_ovf", {31'd0, overflow}, 32'd0);
      chk("clr_keeps_count", {27'd0, count}, 32'd8);
      for (int i = 0; i < 8; i++) do_read("drain_rd");
      chk("drain_empty", {31'd0, empty}, 32'd1);

      // Full FIFO: simultaneous write edge and read.
      for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i), 1'b1);
      Rx_DATA = 8'h18; Rx_VALID = 1'b1; rd_en = 1'b1;
      tick();
      Rx_VALID = 1'b0; rd_en = 1'b0;
      chk("rw_full_vld", {31'd0, rd_valid}, 32'd1);
      chk("rw_full_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      last_rd = rd_data;
      chk("rw_full_count", {27'd0, count}, 32'd8);
      chk("rw_full_ovf", {31'd0, overflow}, 32'd0);
      sb.push_back(8'h18);
      tick();
      for (int i = 0; i < 8; i++) do_read("rw_full_drain");
      chk("rw_full_last", {24'd0, last_rd}, 32'h18);

      // Error counters: saturation, clear, clear-wins, no data writes.
      for (int i = 0; i < 300; i++) begin
         Rx_FERROR = 1'b1; tick();
         Rx_FERROR = 1'b0; tick();
      end
      chk("ferr_sat", {24'd0, ferr_count}, 32'd255);
      chk("ferr_no_data", {27'd0, count}, 32'd0);
      chk("ferr_perr0", {24'd0, perr_count}, 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("ferr_clr", {24'd0, ferr_count}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         Rx_PERROR = 1'b1; tick();
         Rx_PERROR = 1'b0; tick();
      end
      chk("perr_3", {24'd0, perr_count}, 32'd3);
      clr_err = 1'b1; Rx_FERROR = 1'b1; Rx_PERROR = 1'b1;
      tick();
      clr_err = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
      chk("clr_wins_ferr", {24'd0, ferr_count}, 32'd0);
      chk("clr_wins_perr", {24'd0, perr_count}, 32'd0);
      tick();

      // Read while empty is ignored; write plus read while empty writes only.
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("empty_rd_vld", {31'd0, rd_valid}, 32'd0);
      chk("empty_rd_hold", {24'd0, rd_data}, {24'd0, last_rd});
      Rx_DATA = 8'h3C; Rx_VALID = 1'b1; rd_en = 1'b1;
      tick();
      Rx_VALID = 1'b0; rd_en = 1'b0;
      chk("we_empty_count", {27'd0, count}, 32'd1);
      chk("we_empty_vld", {31'd0, rd_valid}, 32'd0);
      sb.push_back(8'h3C);
      tick();
      do_read("we_empty_rd");

      // Mid-stream reset discards data; Rx_VALID high at release is one write.
      for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i), 1'b1);
      chk("pre_rst_count", {27'd0, count}, 32'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_count", {27'd0, count}, 32'd0);
      chk("async_rst_empty", {31'd0, empty}, 32'd1);
      chk("async_rst_rd_data", {24'd0, rd_data}, 32'd0);
      sb.delete();
      Rx_DATA = 8'h77; Rx_VALID = 1'b1;
      tick();
      chk("in_rst_count", {27'd0, count}, 32'd0);
      reset = 1'b1;
      tick();
      chk("release_write", {27'd0, count}, 32'd1);
      sb.push_back(8'h77);
      Rx_VALID = 1'b0;
      tick();
      chk("release_single", {27'd0, count}, 32'd1);
      do_read("post_rst_rd");
      chk("post_rst_empty", {31'd0, empty}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
